// File: rtl/output_ram_pkg.sv
// ----------------------------------------------------------------------------
// output_ram_pkg
// Shared constants and types for the play_gif frame output RAM and its
// sequencing controller. The RAM and the controller both import this package
// so that address and word widths cannot drift apart.
//   DEPTH  : number of RAM entries used as a circular FIFO (legal 2..16)
//   ADDR_W : RAM address width (fixed by the RAM port)
//   DATA_W : RAM word width
//   OUT_W  : display beat width, half a RAM word
//   CNT_W  : occupancy counter width, wide enough to hold 0..DEPTH
// ----------------------------------------------------------------------------
package output_ram_pkg;

    localparam int DEPTH  = 5;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 64;
    localparam int OUT_W  = DATA_W / 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [OUT_W-1:0]  beat_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Which half of the current RAM word is being presented to the display.
    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } half_t;

    // Count of DEPTH expressed in counter width, used for full/ready decode.
    function automatic cnt_t depth_cnt();
        return cnt_t'(DEPTH);
    endfunction

endpackage

// File: rtl/output_ram_ctrl_ring_ptr.sv
// ----------------------------------------------------------------------------
// ring_ptr
// Modulo-DEPTH pointer used for the write and read sides of the output RAM
// FIFO. Advances by one on i_inc and wraps DEPTH-1 -> 0. i_clear returns it
// to 0 synchronously and wins over i_inc. Upper address bits beyond what
// DEPTH needs stay zero.
//   i_clk      : system clock
//   i_reset_p  : asynchronous active-high reset
//   i_clear    : synchronous clear (frame restart)
//   i_inc      : advance pointer at the next edge
//   o_ptr      : current pointer value (registered)
// ----------------------------------------------------------------------------
module ring_ptr #(
    parameter int DEPTH  = 5,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_p,
    input  logic              i_clear,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_ptr
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_next_s;

    // Next pointer: clear first, then wrap-aware increment, else hold.
    always_comb begin
        ptr_next_s = ptr_r;
        if (i_clear) begin
            ptr_next_s = {ADDR_W{1'b0}};
        end else if (i_inc) begin
            if (ptr_r == PTR_LAST) begin
                ptr_next_s = {ADDR_W{1'b0}};
            end else begin
                ptr_next_s = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Pointer register.
    always_ff @(posedge i_clk or posedge i_reset_p) begin
        if (i_reset_p) begin
            ptr_r <= {ADDR_W{1'b0}};
        end else begin
            ptr_r <= ptr_next_s;
        end
    end

    assign o_ptr = ptr_r;

endmodule

// File: rtl/output_ram_ctrl.sv
// ----------------------------------------------------------------------------
// output_ram_ctrl
// Sequencing controller for the 5-entry x 64-bit frame output RAM. The RAM is
// used as a circular FIFO: 64-bit words arrive from the decoder stage over a
// valid/ready handshake and leave towards the display as two 32-bit beats,
// low half first. The controller drives every RAM port; the RAM sits next to
// it in the parent and has a combinational read.
//
// Ports
//   i_clk, i_reset_p      : clock, asynchronous active-high reset
//   i_flush               : synchronous clear of pointers, count and half
//   i_valid/i_data/o_ready: producer word handshake
//   o_valid/o_data/i_ready: consumer beat handshake
//   o_count/o_full/o_empty: occupancy status
//   o_ram_*               : RAM write data, addresses, write and read enables
//   i_ram_rdata           : RAM read data (combinational from o_ram_addr_r)
// ----------------------------------------------------------------------------
module output_ram_ctrl
    import output_ram_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_p,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [OUT_W-1:0]  o_data,
    input  logic              i_ready,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic [ADDR_W-1:0] o_ram_addr_w,
    output logic [ADDR_W-1:0] o_ram_addr_r,
    output logic              o_ram_write,
    output logic              o_ram_read,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    addr_t wr_ptr_s;
    addr_t rd_ptr_s;
    cnt_t  count_r;
    cnt_t  count_next_s;
    half_t half_r;
    half_t half_next_s;

    logic  ready_s;
    logic  valid_s;
    logic  push_s;
    logic  beat_acc_s;
    logic  pop_word_s;
    beat_t beat_s;

    // Ready depends only on the registered count so a same-cycle pop cannot
    // open the input; the producer sees space one cycle after it appears.
    assign ready_s    = (count_r < depth_cnt());
    assign valid_s    = (count_r != {CNT_W{1'b0}});
    assign push_s     = i_valid & ready_s;
    assign beat_acc_s = valid_s & i_ready;
    assign pop_word_s = beat_acc_s & (half_r == HALF_HI);

    ring_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wr_ptr (
        .i_clk     (i_clk),
        .i_reset_p (i_reset_p),
        .i_clear   (i_flush),
        .i_inc     (push_s),
        .o_ptr     (wr_ptr_s)
    );

    ring_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rd_ptr (
        .i_clk     (i_clk),
        .i_reset_p (i_reset_p),
        .i_clear   (i_flush),
        .i_inc     (pop_word_s),
        .o_ptr     (rd_ptr_s)
    );

    // Half-select state: toggles on every accepted beat, holds under backpressure.
    always_comb begin
        half_next_s = half_r;
        case (half_r)
            HALF_LO: begin
                if (beat_acc_s) begin
                    half_next_s = HALF_HI;
                end else begin
                    half_next_s = HALF_LO;
                end
            end
            HALF_HI: begin
                if (beat_acc_s) begin
                    half_next_s = HALF_LO;
                end else begin
                    half_next_s = HALF_HI;
                end
            end
            default: begin
                half_next_s = HALF_LO;
            end
        endcase
    end

    // Half-select state register; flush abandons a half-delivered word.
    always_ff @(posedge i_clk or posedge i_reset_p) begin
        if (i_reset_p) begin
            half_r <= HALF_LO;
        end else if (i_flush) begin
            half_r <= HALF_LO;
        end else begin
            half_r <= half_next_s;
        end
    end

    // Occupancy: +1 on push, -1 on completed word, unchanged when both happen.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_word_s})
            2'b10: begin
                count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            2'b01: begin
                count_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
            default: begin
                count_next_s = count_r;
            end
        endcase
    end

    // Occupancy register; flush overrides any coincident push or pop.
    always_ff @(posedge i_clk or posedge i_reset_p) begin
        if (i_reset_p) begin
            count_r <= {CNT_W{1'b0}};
        end else if (i_flush) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    // Beat selection from the combinational RAM read, zero when nothing is held.
    always_comb begin
        beat_s = {OUT_W{1'b0}};
        if (valid_s) begin
            if (half_r == HALF_HI) begin
                beat_s = i_ram_rdata[DATA_W-1:OUT_W];
            end else begin
                beat_s = i_ram_rdata[OUT_W-1:0];
            end
        end else begin
            beat_s = {OUT_W{1'b0}};
        end
    end

    assign o_ready      = ready_s;
    assign o_valid      = valid_s;
    assign o_data       = beat_s;
    assign o_count      = count_r;
    assign o_full       = (count_r == depth_cnt());
    assign o_empty      = ~valid_s;

    // A flush coincident with a push still writes the RAM; the entry is simply
    // forgotten because the pointers and count are cleared at the same edge.
    assign o_ram_write  = push_s;
    assign o_ram_addr_w = wr_ptr_s;
    assign o_ram_wdata  = i_data;
    assign o_ram_read   = valid_s;
    assign o_ram_addr_r = rd_ptr_s;

endmodule

// File: tb/tb_output_ram_ctrl.sv
module tb_output_ram_ctrl;

    localparam int DEPTH = 5;

    logic        i_clk = 1'b0;
    logic        i_reset_p = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic [63:0] i_data = 64'd0;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic        i_ready = 1'b0;
    logic [2:0]  o_count;
    logic        o_full;
    logic        o_empty;
    logic [63:0] o_ram_wdata;
    logic [3:0]  o_ram_addr_w;
    logic [3:0]  o_ram_addr_r;
    logic        o_ram_write;
    logic        o_ram_read;
    logic [63:0] i_ram_rdata;

    // Bench-side RAM: synchronous write, combinational read.
    logic [63:0] mem [16];

    always @(posedge i_clk) begin
        if (o_ram_write) mem[o_ram_addr_w] <= o_ram_wdata;
    end
    assign i_ram_rdata = mem[o_ram_addr_r];

    always #5 i_clk = ~i_clk;

    output_ram_ctrl dut (
        .i_clk        (i_clk),
        .i_reset_p    (i_reset_p),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .i_ready      (i_ready),
        .o_count      (o_count),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_ram_wdata  (o_ram_wdata),
        .o_ram_addr_w (o_ram_addr_w),
        .o_ram_addr_r (o_ram_addr_r),
        .o_ram_write  (o_ram_write),
        .o_ram_read   (o_ram_read),
        .i_ram_rdata  (i_ram_rdata)
    );

    // Reference model: queue of held words, which half is next, slot indices.
    logic [63:0] q[$];
    bit          m_half;
    int          m_wr;
    int          m_rd;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_half = 1'b0;
        m_wr   = 0;
        m_rd   = 0;
    endtask

    // One clock cycle: drive, check pre-edge outputs against the model, advance.
    task automatic step(input logic v, input logic [63:0] d, input logic r, input logic f);
        logic [63:0] front;
        logic [31:0] exp_data;
        bit          exp_ready, exp_valid, push, acc, pop;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        i_flush = f;
        @(negedge i_clk);
        exp_ready = (q.size() < DEPTH);
        exp_valid = (q.size() > 0);
        exp_data  = 32'd0;
        if (exp_valid) begin
            front    = q[0];
            exp_data = m_half ? front[63:32] : front[31:0];
        end
        push = v && exp_ready;
        acc  = exp_valid && r;
        pop  = acc && m_half;
        chk("ready",    {63'd0, o_ready},     {63'd0, exp_ready});
        chk("valid",    {63'd0, o_valid},     {63'd0, exp_valid});
        chk("empty",    {63'd0, o_empty},     {63'd0, !exp_valid});
        chk("full",     {63'd0, o_full},      {63'd0, q.size() == DEPTH});
        chk("count",    {61'd0, o_count},     64'(q.size()));
        chk("ram_read", {63'd0, o_ram_read},  {63'd0, exp_valid});
        chk("data",     {32'd0, o_data},      {32'd0, exp_data});
        chk("ram_write",{63'd0, o_ram_write}, {63'd0, push});
        if (exp_valid) chk("addr_r", {60'd0, o_ram_addr_r}, 64'(m_rd));
        if (push) begin
            chk("addr_w", {60'd0, o_ram_addr_w}, 64'(m_wr));
            chk("wdata",  o_ram_wdata, d);
        end
        @(posedge i_clk);
        #1;
        if (f) begin
            model_clear();
        end else begin
            if (pop) begin
                void'(q.pop_front());
                m_rd = (m_rd + 1) % DEPTH;
            end
            if (push) begin
                q.push_back(d);
                m_wr = (m_wr + 1) % DEPTH;
            end
            if (acc) m_half = !m_half;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b0;
    endtask

    // Asynchronous reset applied away from the clock edge; checked immediately.
    task automatic apply_reset();
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_flush   = 1'b0;
        i_reset_p = 1'b1;
        #1;
        chk("rst_count", {61'd0, o_count},     64'd0);
        chk("rst_valid", {63'd0, o_valid},     64'd0);
        chk("rst_ready", {63'd0, o_ready},     64'd1);
        chk("rst_empty", {63'd0, o_empty},     64'd1);
        chk("rst_full",  {63'd0, o_full},      64'd0);
        chk("rst_data",  {32'd0, o_data},      64'd0);
        chk("rst_write", {63'd0, o_ram_write}, 64'd0);
        chk("rst_read",  {63'd0, o_ram_read},  64'd0);
        model_clear();
        @(negedge i_clk);
        i_reset_p = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        model_clear();
        repeat (2) @(posedge i_clk);
        #1;
        apply_reset();

        // Single word streamed as low then high beat, written to address 0.
        step(1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);

        // Fill to full with the consumer stalled, then offer a sixth word.
        for (int i = 0; i < 5; i++) step(1'b1, rnd64(), 1'b0, 1'b0);
        step(1'b1, rnd64(), 1'b0, 1'b0);
        step(1'b1, rnd64(), 1'b0, 1'b0);

        // At full with producer and consumer both active continuously.
        for (int i = 0; i < 12; i++) step(1'b1, rnd64(), 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 64'd0, 1'b1, 1'b0);

        // From cleared pointers: 7 words each drained before the next (wrap).
        step(1'b0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, rnd64(), 1'b0, 1'b0);
            step(1'b0, 64'd0, 1'b1, 1'b0);
            step(1'b0, 64'd0, 1'b1, 1'b0);
        end

        // Backpressure after the low beat: high beat must hold for 3 cycles.
        step(1'b1, rnd64(), 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), rnd64(), 1'($urandom_range(0, 3) != 0), 1'b0);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 64'd0, 1'b1, 1'b0);

        // Flush with 3 words held and half=1, coincident push discarded.
        for (int i = 0; i < 3; i++) step(1'b1, rnd64(), 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        step(1'b1, rnd64(), 1'b1, 1'b1);
        step(1'b1, rnd64(), 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);

        // Asynchronous reset with 3 words held and half=1.
        for (int i = 0; i < 3; i++) step(1'b1, rnd64(), 1'b0, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        apply_reset();
        step(1'b1, rnd64(), 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_ram_ctrl.md
Name: output_ram_ctrl

Overview:
Sequencing controller for the 5-entry x 64-bit frame output RAM in the play_gif pipeline. It uses the RAM as a circular FIFO. It accepts 64-bit words from the pixel/decoder stage through a valid/ready handshake. It then streams each word to the display side as two 32-bit beats, low half first. The controller owns every RAM port (write enable, write/read addresses, read enable); the RAM itself is instantiated alongside it in the parent.

Parameters:
DEPTH, 5, number of RAM entries used; legal range 2..16.
ADDR_W, 4, RAM address width; fixed by the RAM port width.
DATA_W, 64, RAM word width.
OUT_W, 32, output beat width; always DATA_W/2.
CNT_W, 3, occupancy counter width, $clog2(DEPTH+1).

Ports:
i_clk  in  1  system clock
i_reset_p  in  1  reset, asynchronous, active-high
i_flush  in  1  synchronous clear of all pointers and state (frame restart)
i_valid  in  1  producer word valid
i_data  in  DATA_W  producer word
o_ready  out  1  controller can accept a word
o_valid  out  1  output beat valid
o_data  out  OUT_W  output beat
i_ready  in  1  consumer accepts beat
o_count  out  CNT_W  words held (0..DEPTH)
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_ram_wdata  out  DATA_W  to RAM i_wdata
o_ram_addr_w  out  ADDR_W  to RAM i_addr_w
o_ram_addr_r  out  ADDR_W  to RAM i_addr_r
o_ram_write  out  1  to RAM i_write
o_ram_read  out  1  to RAM i_read
i_ram_rdata  in  DATA_W  from RAM o_rdata (combinational read)

Behaviour:
- Reset (async, i_reset_p=1): wr_ptr=0, rd_ptr=0, count=0, half=0. Outputs: o_ready=1, o_valid=0, o_empty=1, o_full=0, o_count=0, o_ram_write=0, o_ram_read=0, o_data=0.
- push = i_valid & o_ready. o_ready = (count < DEPTH), registered-state only; no dependence on same-cycle pop.
- On push: o_ram_write=1, o_ram_addr_w=wr_ptr, o_ram_wdata=i_data, all combinational. wr_ptr advances at the edge, DEPTH-1 -> 0.
- o_valid = !o_empty. o_ram_read = o_valid. o_ram_addr_r = rd_ptr.
- o_data = half ? i_ram_rdata[63:32] : i_ram_rdata[31:0]. Forced to 0 when o_valid=0.
- Beat accepted when o_valid & i_ready:
  - half=0 -> half becomes 1.
  - half=1 -> half becomes 0, rd_ptr advances (wraps DEPTH-1 -> 0); this is pop_word.
- Latency: a word pushed at edge N is presented as a low beat in cycle N+1 at the earliest. There is no write-to-read bypass.
- count next = count + push - pop_word. Simultaneous push and pop_word leaves count unchanged.
- Full: a pop_word in the same cycle does not raise o_ready. o_ready rises in the cycle after count drops.
- Backpressure: while i_ready=0, o_data, half and rd_ptr hold stable.
- Flush: clears wr_ptr, rd_ptr, count and half at the edge. Flush overrides push and pop in the same cycle; the RAM write for a coincident push still occurs but is discarded. RAM contents are not cleared.
- Reset asserted mid-operation: immediate return to reset values. A half-delivered word is dropped.
- DEPTH must be <= 2**ADDR_W. Pointer upper address bits are zero-extended.

Decomposition:
- Shared package output_ram_pkg: DEPTH, ADDR_W, DATA_W, OUT_W, CNT_W constants, plus typedefs addr_t and word_t (used by both the RAM and the controller).
- One natural sub-module: ring_ptr, a modulo-DEPTH pointer with increment and clear, instantiated twice (write and read pointers).
- Half/beat logic and the counter stay inline.

Test Plan:
- Reset then push 0x11112222_33334444, i_ready=1 -> beats 0x33334444 then 0x11112222 in cycles N+1 and N+2; o_empty=1 afterwards; o_ram_addr_w=0.
- Push 5 words with i_ready=0 -> o_count=5, o_full=1, o_ready=0; a sixth i_valid is not written (o_ram_write=0).
- Push 7 words interleaved with drains -> 6th and 7th words written to addresses 0 and 1 (wrap); output order matches input, 14 beats.
- At full, assert i_valid and i_ready continuously -> o_ready=0 in the pop cycle and 1 the cycle after; count goes 5->4->5; no data loss.
- Hold i_ready=0 after the low beat for 3 cycles -> high beat held stable on o_data; rd_ptr unchanged.
- With 3 words held, half=1: assert i_flush, then separately i_reset_p -> o_count=0, o_valid=0, half=0; the next push lands at address 0.
